// File: rtl/fetch_controller.sv
// Instruction-fetch sequencer: owns the PC, drives the combinational imem address and
// buffers {pc, instr} pairs in a 2-entry queue toward decode; redirect flushes, bad fetches fault.
module fetch_controller #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter int unsigned IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic [63:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fetch_fault
);

  localparam logic [0:0] RUN   = 1'b0;
  localparam logic [0:0] FAULT = 1'b1;

  logic [0:0]  state;
  logic [63:0] pc;
  logic [1:0]  count;
  logic [63:0] q_pc0, q_pc1;
  logic [31:0] q_instr0, q_instr1;

  logic pop, can_push, legal, fetch, push;

  // Entry 0 is always the head; entry 1 shifts down on a pop.
  always_comb begin
    pop      = (count != 2'd0) && out_ready;
    can_push = (count < 2'd2) || pop;
    legal    = (pc[1:0] == 2'b00) && (pc < 64'(IMEM_BYTES));
    fetch    = (state == RUN) && can_push && !redirect_valid;
    push     = fetch && legal;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc    <= RESET_PC;
      count <= '0;
      state <= RUN;
    end else if (redirect_valid) begin
      pc    <= redirect_pc;
      count <= '0;
      state <= RUN;
    end else begin
      if (fetch && !legal) state <= FAULT;
      if (push) pc <= pc + 64'd4;
      case ({push, pop})
        2'b11: begin
          if (count == 2'd2) begin
            q_pc0    <= q_pc1;
            q_instr0 <= q_instr1;
            q_pc1    <= pc;
            q_instr1 <= imem_data;
          end else begin
            q_pc0    <= pc;
            q_instr0 <= imem_data;
          end
        end
        2'b01: begin
          q_pc0    <= q_pc1;
          q_instr0 <= q_instr1;
          count    <= count - 2'd1;
        end
        2'b10: begin
          if (count == 2'd0) begin
            q_pc0    <= pc;
            q_instr0 <= imem_data;
          end else begin
            q_pc1    <= pc;
            q_instr1 <= imem_data;
          end
          count <= count + 2'd1;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr   = pc;
  assign out_valid   = (count != 2'd0);
  assign out_pc      = q_pc0;
  assign out_instr   = q_instr0;
  assign fetch_fault = (state == FAULT);

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Sequencer for the instruction-fetch datapath. Owns the 64-bit program counter, drives the combinational instruction memory address, and buffers fetched {pc, instruction} pairs in a 2-entry queue toward decode with a valid/ready handshake. Handles taken-branch/jump redirects by flushing the queue, and raises a sticky fault on misaligned or out-of-range fetch addresses. It replaces the free-running PC + 4 / mux path with stall- and redirect-aware sequencing.

## Interface
- RESET_PC, 64'h0, PC loaded on reset
- IMEM_BYTES, 1024, instruction memory size in bytes; a fetch address at or above this faults

- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- imem_addr  out  64  fetch address to instruction memory; equals internal pc, combinational
- imem_data  in  32  instruction word at imem_addr, same cycle (combinational memory)
- redirect_valid  in  1  taken branch/jump this cycle
- redirect_pc  in  64  redirect target, sampled when redirect_valid=1
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head this cycle
- out_pc  out  64  PC of queue head
- out_instr  out  32  instruction of queue head
- fetch_fault  out  1  sticky fetch fault flag

## Operation
- State: pc (64b), queue of 2 entries {pc, instr}, count (0..2), FSM {RUN, FAULT}.
- pop = out_valid & out_ready. Head advances on pop.
- can_push = (count < 2) | pop.
- Fetch attempt occurs in RUN when can_push=1 and redirect_valid=0:
  - legal (pc[1:0]==0 and pc < IMEM_BYTES): push {pc, imem_data}; pc <= pc + 4 (64-bit wrap, no carry out).
  - illegal: no push, pc holds, FSM -> FAULT, fetch_fault <= 1.
- RUN with can_push=0: pc holds, no push (stall); imem_addr stays at pc.
- FAULT: no fetches; queue continues to drain via pops; pc holds.
- Redirect (highest priority, either state): a pop in the same cycle is honoured (head consumed), then the entire queue is flushed (count <= 0); pc <= redirect_pc; FSM -> RUN; fetch_fault <= 0; no push that cycle. Legality of redirect_pc is checked on the next fetch attempt.
- Simultaneous push and pop: count unchanged, FIFO order preserved.
- out_pc/out_instr are don't-care while out_valid=0; hold stable while out_valid=1 and out_ready=0.

## Timing
- Reset (rst=1 at edge): pc <= RESET_PC, count <= 0, FSM <= RUN, fetch_fault <= 0. Outputs after reset: out_valid=0, fetch_fault=0, imem_addr=RESET_PC. Reset mid-operation discards queue and fault identically.
- First fetch in the first cycle with rst=0; out_valid=1 on the following cycle with out_pc=RESET_PC.
- Fetch-to-valid latency: 1 cycle. Throughput: 1 instruction/cycle with out_ready held high.
- Redirect at edge N: out_valid=0 in cycle N+1; target fetched in N+1; out_pc=redirect_pc valid in N+2.
- Fault: illegal fetch attempt in cycle N -> fetch_fault=1 from cycle N+1 until a redirect or reset edge.
- Backpressure: with out_ready=0 the queue fills in 2 cycles; pc then stalls at head_pc+8.

## Test plan
- Reset, RESET_PC=0, out_ready=1, memory word k = k+100 -> out_valid rises 1 cycle after rst falls; out_pc 0,4,8,12 on consecutive cycles, out_instr 100,101,102,103.
- out_ready=0 for 5 cycles after first valid -> out_pc held 0, imem_addr held 8, count 2; release -> out_pc 0,4,8 on consecutive cycles, no gaps or duplicates.
- Queue full (pc 0,4 buffered), redirect_valid=1, redirect_pc=0x40 with out_ready=1 -> entry 0 consumed, next cycle out_valid=0, following cycle out_pc=0x40, out_instr=word 16.
- Redirect to 0x42 -> fetch_fault=1 two cycles later, out_valid=0, imem_addr=0x42 held; redirect to 0x10 -> fetch_fault=0 next cycle, out_pc=0x10 one cycle after that.
- IMEM_BYTES=32, sequential run from 0 -> last valid out_pc=28; fetch_fault=1 with imem_addr=32; no further pushes.
- rst asserted for one cycle with queue full and fetch_fault=1 -> next cycle out_valid=0, fetch_fault=0, imem_addr=RESET_PC; normal sequence resumes.
